// File: rtl/fc_l2_port_arbiter_if.sv
// Bundle of the fabric-controller requester buses and the shared L2 TCDM master port.
// Names keep the requester (s_*) / L2 (m_*) split as seen from the arbiter.
interface fc_l2_port_arbiter_if #(
    parameter int NB_PORTS   = 2,
    parameter int ADDR_WIDTH = 32
);
    // TCDM handshake: a request is accepted in the cycle where req and gnt are both high.
    // Request fields must stay stable while req is high and gnt is low. r_valid arrives
    // in order, at least one cycle after the grant, one per accepted request.
    logic [NB_PORTS-1:0]                 s_req_i;
    logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] s_add_i;
    logic [NB_PORTS-1:0]                 s_wen_i;
    logic [NB_PORTS-1:0][31:0]           s_wdata_i;
    logic [NB_PORTS-1:0][3:0]            s_be_i;
    logic [NB_PORTS-1:0]                 s_gnt_o;
    logic [NB_PORTS-1:0]                 s_r_valid_o;
    logic [31:0]                         s_r_rdata_o;

    logic                  m_req_o;
    logic [ADDR_WIDTH-1:0] m_add_o;
    logic                  m_wen_o;
    logic [31:0]           m_wdata_o;
    logic [3:0]            m_be_o;
    logic                  m_gnt_i;
    logic                  m_r_valid_i;
    logic [31:0]           m_r_rdata_i;

    // slave: the arbiter's view; master: the requesters plus the L2 memory around it.
    modport slave (
        input  s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
        output s_gnt_o, s_r_valid_o, s_r_rdata_o,
        output m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
        input  m_gnt_i, m_r_valid_i, m_r_rdata_i
    );

    modport master (
        output s_req_i, s_add_i, s_wen_i, s_wdata_i, s_be_i,
        input  s_gnt_o, s_r_valid_o, s_r_rdata_o,
        input  m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o,
        output m_gnt_i, m_r_valid_i, m_r_rdata_i
    );
endinterface

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port among NB_PORTS FC requesters,
// with an in-order ID FIFO that routes each response back to its issuer.
module fc_l2_port_arbiter #(
    parameter int NB_PORTS        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    fc_l2_port_arbiter_if.slave                  bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 rsp_err_o
);
    localparam int IDW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NB_PORTS - 1);

    logic [IDW-1:0] rr_q, sel_q, rr_pick, winner;
    logic           lock_q, lock_eff, grant_hs, pop, found;
    logic [CW-1:0]  cnt_q;
    logic [PW-1:0]  head_q, tail_q;
    logic [IDW-1:0] id_fifo_q [MAX_OUTSTANDING];
    int unsigned    idx;

    // First requester at or after rr_q, in cyclic order.
    always_comb begin
        rr_pick = rr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NB_PORTS; i++) begin
            idx = (int'(rr_q) + i) % NB_PORTS;
            if (!found && bus.s_req_i[idx]) begin
                found   = 1'b1;
                rr_pick = IDW'(idx);
            end
        end
    end

    // A locked requester that withdraws frees the port in the same cycle.
    assign lock_eff = lock_q & bus.s_req_i[sel_q];
    assign winner   = lock_eff ? sel_q : rr_pick;

    assign bus.m_req_o   = bus.s_req_i[winner] & (cnt_q < MAX_CNT);
    assign bus.m_add_o   = bus.s_add_i[winner];
    assign bus.m_wen_o   = bus.s_wen_i[winner];
    assign bus.m_wdata_o = bus.s_wdata_i[winner];
    assign bus.m_be_o    = bus.s_be_i[winner];

    assign grant_hs = bus.m_req_o & bus.m_gnt_i;
    assign pop      = bus.m_r_valid_i & (cnt_q != '0);

    always_comb begin
        bus.s_gnt_o = '0;
        if (grant_hs) bus.s_gnt_o[winner] = 1'b1;
    end

    always_comb begin
        bus.s_r_valid_o = '0;
        if (pop) bus.s_r_valid_o[id_fifo_q[head_q]] = 1'b1;
    end

    assign bus.s_r_rdata_o = bus.m_r_rdata_i;
    assign rsp_err_o       = bus.m_r_valid_i & (cnt_q == '0);
    assign outstanding_o   = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            sel_q  <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (grant_hs) begin
                rr_q   <= (winner == LAST_IDX) ? '0 : winner + IDW'(1);
                lock_q <= 1'b0;
                tail_q <= tail_q + PW'(1);
            end else if (bus.m_req_o) begin
                lock_q <= 1'b1;
                sel_q  <= winner;
            end else if (lock_q && !bus.s_req_i[sel_q]) begin
                lock_q <= 1'b0;
            end

            if (pop) head_q <= head_q + PW'(1);

            case ({grant_hs, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry contents are only read below the count, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (grant_hs) id_fifo_q[tail_q] <= winner;
    end
endmodule
